// File: rtl/stupidrv_mmio_out.sv
// Memory-mapped output port: stores to the DATA register queue words into a FIFO that
// drains over a valid/ready stream; STATUS exposes overflow/full/empty/count.
module stupidrv_mmio_out #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_sel,
  output logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic        is_write;
  logic        push_req;
  logic        stat_wr;
  logic        stat_rd;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic [31:0] wr_word;
  logic [31:0] status;

  // Byte offset within a register is irrelevant: registers are whole words.
  logic [1:0] unused_addr;
  assign unused_addr = dmem_addr[1:0];

  always_comb begin
    dmem_sel = dmem_valid && (dmem_addr[31:3] == BASE_ADDR[31:3]);
    is_write = |dmem_wstrb;
    push_req = dmem_sel && !dmem_addr[2] && is_write;
    stat_wr  = dmem_sel && dmem_addr[2] && is_write;
    stat_rd  = dmem_sel && dmem_addr[2] && !is_write;

    full  = (cnt_q == CntW'(DEPTH));
    empty = (cnt_q == '0);
    pop   = !empty && out_ready;
    // A push into a full FIFO still fits if the head leaves in the same cycle.
    push_ok = push_req && (!full || pop);
    drop    = push_req && full && !pop;

    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = dmem_wstrb[i] ? dmem_wdata[8*i +: 8] : 8'h00;
    end

    status = {overflow_q, full, empty, 13'b0, 16'(cnt_q)};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop);

    overflow_d = overflow_q;
    if (stat_wr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;

    rdata_d = stat_rd ? status : 32'h0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage is deliberately unreset; out_data is meaningless while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_word;
  end

  assign out_valid  = !empty;
  assign out_data   = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;
  assign dmem_rdata = rdata_q;

endmodule

// File: tb/tb_stupidrv_mmio_out.sv
// Directed and table-driven checks for stupidrv_mmio_out (DEPTH=8).
module tb_stupidrv_mmio_out;

  localparam int unsigned Depth = 8;
  localparam logic [31:0] Base  = 32'h0200_0000;
  localparam logic [31:0] Stat  = 32'h0200_0004;

  logic        clock = 1'b0;
  logic        reset;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_sel;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  stupidrv_mmio_out #(
    .DEPTH    (Depth),
    .BASE_ADDR(Base)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .dmem_valid(dmem_valid),
    .dmem_addr (dmem_addr),
    .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata),
    .dmem_sel  (dmem_sel),
    .dmem_rdata(dmem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        r;
    logic        e_sel;
    logic        e_vld;
    logic [31:0] e_dat;
    logic [31:0] e_rd;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // One bus cycle: drive on the falling edge, sample just after the rising edge.
  task automatic bus(input logic v, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic r);
    @(negedge clock);
    dmem_valid = v;
    dmem_addr  = a;
    dmem_wstrb = s;
    dmem_wdata = d;
    out_ready  = r;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(logic v, logic [31:0] a, logic [3:0] s, logic [31:0] d, logic r,
                              logic e_sel, logic e_vld, logic [31:0] e_dat, logic [31:0] e_rd,
                              logic e_ovf);
    vec_t t;
    t.v = v; t.a = a; t.s = s; t.d = d; t.r = r;
    t.e_sel = e_sel; t.e_vld = e_vld; t.e_dat = e_dat; t.e_rd = e_rd; t.e_ovf = e_ovf;
    return t;
  endfunction

  logic [31:0] sb[$];
  logic [31:0] exp_w;

  initial begin
    int mcnt;
    int pushed;
    int received;
    int cyc;
    logic r;
    logic p;
    logic [31:0] wd;
    logic [31:0] drain[8];

    reset      = 1'b0;
    dmem_valid = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wstrb = 4'h0;
    dmem_wdata = 32'h0;
    out_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_overflow", {31'b0, overflow}, 32'h0);
    check("rst_rdata", dmem_rdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Main directed table
    vecs.push_back(mk(1, Base, 4'hF, 32'h2A, 0, 1, 1, 32'h2A, 0, 0));
    vecs.push_back(mk(1, Stat, 4'h0, 32'h0, 0, 1, 1, 32'h2A, 32'h1, 0));
    vecs.push_back(mk(0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, Base, 4'b0101, 32'hAABBCCDD, 0, 1, 1, 32'h00BB00DD, 0, 0));
    vecs.push_back(mk(0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(1, Base, 4'hF, 32'(i), 0, 1, 1, 32'h1, 0, i == 9));
    vecs.push_back(mk(1, Stat, 4'h0, 32'h0, 0, 1, 1, 32'h1, 32'hC000_0008, 1));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 32'h0, 4'h0, 32'h0, 1, 0, i < 8, 32'(i + 1), 0, 1));
    vecs.push_back(mk(1, Stat, 4'hF, 32'hFFFF_FFFF, 0, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, Stat, 4'h0, 32'h0, 0, 1, 0, 32'h0, 32'h2000_0000, 0));
    vecs.push_back(mk(1, Base, 4'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h0200_0003, 4'hF, 32'h77, 0, 1, 1, 32'h77, 0, 0));
    vecs.push_back(mk(1, 32'h0200_0008, 4'hF, 32'h88, 0, 0, 1, 32'h77, 0, 0));
    vecs.push_back(mk(1, Stat, 4'h0, 32'h0, 0, 1, 1, 32'h77, 32'h1, 0));
    vecs.push_back(mk(0, 32'h0, 4'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0));

    foreach (vecs[i]) begin
      bus(vecs[i].v, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].r);
      check($sformatf("v%0d_sel", i), {31'b0, dmem_sel}, {31'b0, vecs[i].e_sel});
      check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_vld});
      if (vecs[i].e_vld) check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_dat);
      check($sformatf("v%0d_rdata", i), dmem_rdata, vecs[i].e_rd);
      check($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vecs[i].e_ovf});
    end

    // Full FIFO with a simultaneous pop accepts the push
    for (int i = 0; i < 8; i++) bus(1, Base, 4'hF, 32'h100 + 32'(i), 0);
    bus(1, Base, 4'hF, 32'h55, 1);
    check("fullpp_overflow", {31'b0, overflow}, 32'h0);
    bus(1, Stat, 4'h0, 32'h0, 0);
    check("fullpp_status", dmem_rdata, 32'h4000_0008);
    for (int i = 0; i < 7; i++) drain[i] = 32'h101 + 32'(i);
    drain[7] = 32'h55;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fullpp_valid%0d", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("fullpp_data%0d", i), out_data, drain[i]);
      bus(0, 32'h0, 4'h0, 32'h0, 1);
    end
    check("fullpp_empty", {31'b0, out_valid}, 32'h0);

    // Random-ready stream across pointer wrap
    mcnt = 0; pushed = 0; received = 0; cyc = 0;
    while (received < 3 * Depth + 3 && cyc < 2000) begin
      r  = ($urandom_range(0, 2) != 0);
      p  = (pushed < 3 * Depth + 3) && (mcnt < Depth) && ($urandom_range(0, 3) != 0);
      wd = $urandom;
      if (out_valid !== (mcnt != 0)) check("wrap_valid", {31'b0, out_valid}, {31'b0, mcnt != 0});
      if (r && mcnt != 0) begin
        exp_w = sb.pop_front();
        check("wrap_data", out_data, exp_w);
        received++;
        mcnt--;
      end
      if (p) begin
        sb.push_back(wd);
        pushed++;
        mcnt++;
      end
      bus(p, Base, p ? 4'hF : 4'h0, wd, r);
      cyc++;
    end
    check("wrap_received", 32'(received), 32'(3 * Depth + 3));
    check("wrap_overflow", {31'b0, overflow}, 32'h0);
    out_ready = 1'b0;

    // Asynchronous reset mid-drain with 5 entries and overflow pending
    for (int i = 0; i < 9; i++) bus(1, Base, 4'hF, 32'h200 + 32'(i), 0);
    for (int i = 0; i < 3; i++) bus(0, 32'h0, 4'h0, 32'h0, 1);
    check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    check("pre_rst_overflow", {31'b0, overflow}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    check("async_rst_overflow", {31'b0, overflow}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    reset     = 1'b1;
    bus(1, Stat, 4'h0, 32'h0, 0);
    check("post_rst_status", dmem_rdata, 32'h2000_0000);
    bus(1, 32'h0100_0000, 4'h0, 32'h0, 0);
    check("outside_sel", {31'b0, dmem_sel}, 32'h0);
    check("outside_rdata", dmem_rdata, 32'h0);
    bus(0, 32'h0, 4'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
